// File: rtl/usb_rx_packet_decoder.sv
// usb_rx_packet_decoder
// Turns one sampled D+/D- line state per bit-rate clock into a validated
// USB low/full-speed packet stream: NRZI decode, bit unstuffing, SYNC hunt,
// PID check-nibble validation, LSB-first byte assembly and EOP qualification.
//
// Ports
//   clock       bit-rate clock, all state on posedge
//   reset_n     asynchronous active-low reset
//   dp_in/dm_in line sample: {1,0}=J {0,1}=K {0,0}=SE0 {1,1}=SE1
//   rx_en       level enable; low forces IDLE on the next cycle
//   rx_active   high from SYNC detect until packet end/abort
//   pid         PID nibble of the current packet
//   pid_valid   one-cycle pulse when the PID byte is received
//   byte_out    data byte, qualified by byte_valid
//   byte_valid  one-cycle pulse per delivered data byte
//   byte_count  data bytes delivered in the current packet
//   eop_done    one-cycle pulse at packet end
//   pkt_ok      with eop_done: 1 iff no error bit is set
//   rx_err      sticky: [0] PID check [1] stuff [2] dribble/short PID
//               [3] overflow [4] line (SE1, bad EOP)
module usb_rx_packet_decoder #(
  parameter bit         NRZI_EN      = 1'b1,
  parameter bit         UNSTUFF_EN   = 1'b1,
  parameter int         MAX_BYTES    = 64,
  parameter int         HUNT_TIMEOUT = 256,
  parameter logic [7:0] SYNC_PATTERN = 8'h80
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic                           dp_in,
  input  logic                           dm_in,
  input  logic                           rx_en,
  output logic                           rx_active,
  output logic [3:0]                     pid,
  output logic                           pid_valid,
  output logic [7:0]                     byte_out,
  output logic                           byte_valid,
  output logic [$clog2(MAX_BYTES+1)-1:0] byte_count,
  output logic                           eop_done,
  output logic                           pkt_ok,
  output logic [4:0]                     rx_err
);
  localparam int CW = $clog2(MAX_BYTES + 1);
  localparam int TW = $clog2(HUNT_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_BYTES);
  localparam logic [TW-1:0] TMO_LAST = TW'(HUNT_TIMEOUT - 1);

  localparam int E_PID   = 0;
  localparam int E_STUFF = 1;
  localparam int E_SHORT = 2;
  localparam int E_OVF   = 3;
  localparam int E_LINE  = 4;

  typedef enum logic [2:0] {
    S_IDLE, S_HUNT, S_PID, S_DATA, S_EOP1, S_EOP2, S_ERR
  } state_t;

  state_t          state_q, state_d;
  logic            prev_j_q, prev_j_d;
  logic [7:0]      sr_q, sr_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [2:0]      ones_q, ones_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            seen_se0_q, seen_se0_d;
  logic [3:0]      pid_q, pid_d;
  logic            pid_valid_q, pid_valid_d;
  logic [7:0]      byte_q, byte_d;
  logic            byte_valid_q, byte_valid_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            eop_q, eop_d;
  logic            pkt_ok_q, pkt_ok_d;
  logic [4:0]      err_q, err_d;

  logic       line_j, line_ok, se0, se1;
  logic       dec_bit, in_pkt, at_six, stuff_err, byte_done, sync_hit, overflow;
  logic [7:0] shifted;

  assign line_j  = dp_in & ~dm_in;
  assign line_ok = dp_in ^ dm_in;
  assign se0     = ~dp_in & ~dm_in;
  assign se1     = dp_in & dm_in;

  // NRZI: no transition from the previous non-SE0 line state decodes as 1.
  assign dec_bit = NRZI_EN ? (dp_in == prev_j_q) : dp_in;
  assign shifted = {dec_bit, sr_q[7:1]};

  assign in_pkt    = (state_q == S_PID) || (state_q == S_DATA);
  // After six consecutive ones the next bit is a stuff position.
  assign at_six    = UNSTUFF_EN && (ones_q == 3'd6);
  assign stuff_err = in_pkt && line_ok && at_six && dec_bit;
  assign byte_done = in_pkt && line_ok && !at_six && (bit_cnt_q == 3'd7);
  assign sync_hit  = (state_q == S_HUNT) && !se0 && (shifted == SYNC_PATTERN);
  assign overflow  = (state_q == S_DATA) && byte_done && (cnt_q == CNT_MAX);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!rx_en) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: state_d = S_HUNT;
        S_HUNT: begin
          if (sync_hit)                 state_d = S_PID;
          else if (timer_q == TMO_LAST) state_d = S_IDLE;
        end
        S_PID, S_DATA: begin
          if (se1)                                  state_d = S_ERR;
          else if (se0)                             state_d = S_EOP1;
          else if (stuff_err || overflow)           state_d = S_ERR;
          else if (byte_done && state_q == S_PID)   state_d = S_DATA;
        end
        S_EOP1: state_d = se0 ? S_EOP2 : S_ERR;
        S_EOP2: begin
          if (line_j)    state_d = S_HUNT;
          else if (!se0) state_d = S_ERR;
        end
        S_ERR: begin
          if (seen_se0_q && line_j) state_d = S_HUNT;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    prev_j_d     = prev_j_q;
    sr_d         = sr_q;
    bit_cnt_d    = bit_cnt_q;
    ones_d       = ones_q;
    timer_d      = timer_q;
    seen_se0_d   = 1'b0;
    pid_d        = pid_q;
    pid_valid_d  = 1'b0;
    byte_d       = byte_q;
    byte_valid_d = 1'b0;
    cnt_d        = cnt_q;
    eop_d        = 1'b0;
    pkt_ok_d     = 1'b0;
    err_d        = err_q;

    if (!rx_en) begin
      prev_j_d = 1'b1;
    end else begin
      if (!se0) prev_j_d = dp_in;
      unique case (state_q)
        S_IDLE: begin
          // Preload with ones so an idle J line cannot fake a SYNC match.
          sr_d    = 8'hFF;
          timer_d = '0;
        end
        S_HUNT: begin
          timer_d = timer_q + 1'b1;
          if (!se0) sr_d = shifted;
          if (sync_hit) begin
            err_d     = '0;
            cnt_d     = '0;
            bit_cnt_d = '0;
            ones_d    = 3'd1;   // last SYNC bit is a one
          end
        end
        S_PID, S_DATA: begin
          if (line_ok) begin
            if (at_six) begin
              ones_d = '0;
              if (dec_bit) err_d[E_STUFF] = 1'b1;
            end else begin
              ones_d    = dec_bit ? ones_q + 3'd1 : 3'd0;
              sr_d      = shifted;
              bit_cnt_d = bit_cnt_q + 3'd1;
              if (byte_done) begin
                if (state_q == S_PID) begin
                  pid_d       = shifted[3:0];
                  pid_valid_d = 1'b1;
                  if (shifted[7:4] != ~shifted[3:0]) err_d[E_PID] = 1'b1;
                end else if (cnt_q == CNT_MAX) begin
                  err_d[E_OVF] = 1'b1;
                end else begin
                  byte_d       = shifted;
                  byte_valid_d = 1'b1;
                  cnt_d        = cnt_q + 1'b1;
                end
              end
            end
          end else if (se1) begin
            err_d[E_LINE] = 1'b1;
          end else if (state_q == S_PID || bit_cnt_q != 3'd0) begin
            err_d[E_SHORT] = 1'b1;
          end
        end
        S_EOP1: begin
          if (!se0) err_d[E_LINE] = 1'b1;
        end
        S_EOP2: begin
          if (line_j) begin
            eop_d    = 1'b1;
            pkt_ok_d = (err_q == 5'd0);
            sr_d     = 8'hFF;
            timer_d  = '0;
          end else if (!se0) begin
            err_d[E_LINE] = 1'b1;
          end
        end
        S_ERR: begin
          // Abort completes only on SE0 immediately followed by J.
          seen_se0_d = seen_se0_q;
          if (se0) begin
            seen_se0_d = 1'b1;
          end else if (line_j && seen_se0_q) begin
            eop_d   = 1'b1;
            sr_d    = 8'hFF;
            timer_d = '0;
          end else begin
            seen_se0_d = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prev_j_q     <= 1'b1;
      sr_q         <= 8'hFF;
      bit_cnt_q    <= '0;
      ones_q       <= '0;
      timer_q      <= '0;
      seen_se0_q   <= 1'b0;
      pid_q        <= '0;
      pid_valid_q  <= 1'b0;
      byte_q       <= '0;
      byte_valid_q <= 1'b0;
      cnt_q        <= '0;
      eop_q        <= 1'b0;
      pkt_ok_q     <= 1'b0;
      err_q        <= '0;
    end else begin
      prev_j_q     <= prev_j_d;
      sr_q         <= sr_d;
      bit_cnt_q    <= bit_cnt_d;
      ones_q       <= ones_d;
      timer_q      <= timer_d;
      seen_se0_q   <= seen_se0_d;
      pid_q        <= pid_d;
      pid_valid_q  <= pid_valid_d;
      byte_q       <= byte_d;
      byte_valid_q <= byte_valid_d;
      cnt_q        <= cnt_d;
      eop_q        <= eop_d;
      pkt_ok_q     <= pkt_ok_d;
      err_q        <= err_d;
    end
  end

  always_comb begin
    rx_active  = (state_q != S_IDLE) && (state_q != S_HUNT);
    pid        = pid_q;
    pid_valid  = pid_valid_q;
    byte_out   = byte_q;
    byte_valid = byte_valid_q;
    byte_count = cnt_q;
    eop_done   = eop_q;
    pkt_ok     = pkt_ok_q;
    rx_err     = err_q;
  end

endmodule

// File: tb/tb_usb_rx_packet_decoder.sv
// Directed bench for usb_rx_packet_decoder (MAX_BYTES=4, HUNT_TIMEOUT=16).
// Inputs change on the falling edge; outputs are checked on the falling edge,
// and a pulse monitor samples 2 ns after each rising edge.
module tb_usb_rx_packet_decoder;
  logic       clock, reset_n, dp_in, dm_in, rx_en;
  logic       rx_active, pid_valid, byte_valid, eop_done, pkt_ok;
  logic [3:0] pid;
  logic [7:0] byte_out;
  logic [2:0] byte_count;
  logic [4:0] rx_err;

  usb_rx_packet_decoder #(
    .NRZI_EN(1'b1), .UNSTUFF_EN(1'b1), .MAX_BYTES(4),
    .HUNT_TIMEOUT(16), .SYNC_PATTERN(8'h80)
  ) dut (
    .clock(clock), .reset_n(reset_n), .dp_in(dp_in), .dm_in(dm_in),
    .rx_en(rx_en), .rx_active(rx_active), .pid(pid), .pid_valid(pid_valid),
    .byte_out(byte_out), .byte_valid(byte_valid), .byte_count(byte_count),
    .eop_done(eop_done), .pkt_ok(pkt_ok), .rx_err(rx_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int         n_chk = 0;
  int         n_err = 0;
  int         n_pid = 0;
  int         n_byte = 0;
  int         n_eop = 0;
  logic       last_ok = 1'b0;
  logic [7:0] byte_log[$];
  logic       cur_j;
  int         ones;
  int         p0, b0, e0;

  always @(posedge clock) begin
    #2;
    if (pid_valid) n_pid++;
    if (byte_valid) begin
      n_byte++;
      byte_log.push_back(byte_out);
    end
    if (eop_done) begin
      n_eop++;
      last_ok = pkt_ok;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] all_out();
    return {7'd0, rx_active, pid, pid_valid, byte_out, byte_valid, byte_count,
            eop_done, pkt_ok, rx_err};
  endfunction

  task automatic step(input logic dp, input logic dm);
    dp_in = dp;
    dm_in = dm;
    @(negedge clock);
  endtask

  // NRZI: a 0 toggles the line, a 1 holds it.
  task automatic tx_bit(input logic b);
    if (!b) cur_j = ~cur_j;
    step(cur_j, ~cur_j);
  endtask

  task automatic tx_bit_s(input logic b, input bit stuff);
    tx_bit(b);
    if (b) ones++;
    else   ones = 0;
    if (stuff && ones == 6) begin
      tx_bit(1'b0);
      ones = 0;
    end
  endtask

  task automatic tx_byte(input logic [7:0] v, input bit stuff);
    for (int i = 0; i < 8; i++) tx_bit_s(v[i], stuff);
  endtask

  // KJKJKJKK from an idle J line
  task automatic sync_seq();
    cur_j = 1'b1;
    repeat (7) tx_bit(1'b0);
    tx_bit(1'b1);
    ones = 1;
  endtask

  task automatic eop();
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    cur_j = 1'b1;
  endtask

  task automatic start_pkt();
    rx_en = 1'b1;
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    sync_seq();
  endtask

  initial begin
    reset_n = 1'b0; rx_en = 1'b0; dp_in = 1'b1; dm_in = 1'b0;
    cur_j = 1'b1; ones = 0;
    @(negedge clock);
    @(negedge clock);
    chk("reset_outputs", all_out(), 32'h0);
    reset_n = 1'b1;

    // ACK
    p0 = n_pid; e0 = n_eop;
    start_pkt();
    chk("ack_rx_active_rise", 32'(rx_active), 32'h1);
    tx_byte(8'hD2, 1'b1);
    chk("ack_pid_valid", 32'(pid_valid), 32'h1);
    chk("ack_pid", 32'(pid), 32'h2);
    eop();
    chk("ack_eop_done", 32'(eop_done), 32'h1);
    chk("ack_pkt_ok", 32'(pkt_ok), 32'h1);
    chk("ack_rx_active_fall", 32'(rx_active), 32'h0);
    chk("ack_rx_err", 32'(rx_err), 32'h0);
    chk("ack_byte_count", 32'(byte_count), 32'h0);
    chk("ack_pid_pulses", 32'(n_pid - p0), 32'h1);
    chk("ack_eop_pulses", 32'(n_eop - e0), 32'h1);

    // DATA0 0x01 0x02
    b0 = n_byte;
    start_pkt();
    tx_byte(8'hC3, 1'b1);
    chk("d0_pid", 32'(pid), 32'h3);
    tx_byte(8'h01, 1'b1);
    chk("d0_byte_valid", 32'(byte_valid), 32'h1);
    chk("d0_byte_out", 32'(byte_out), 32'h01);
    tx_byte(8'h02, 1'b1);
    eop();
    chk("d0_byte_pulses", 32'(n_byte - b0), 32'h2);
    chk("d0_byte1", 32'(byte_log[b0 + 1]), 32'h02);
    chk("d0_byte_count", 32'(byte_count), 32'h2);
    chk("d0_pkt_ok", 32'(pkt_ok), 32'h1);

    // DATA0 0xFF 0xFF with stuffed zeros, last stuff bit right before SE0
    b0 = n_byte;
    start_pkt();
    tx_byte(8'hC3, 1'b1);
    tx_byte(8'hFF, 1'b1);
    tx_byte(8'hFF, 1'b1);
    eop();
    chk("stuff_byte_pulses", 32'(n_byte - b0), 32'h2);
    chk("stuff_byte0", 32'(byte_log[b0]), 32'hFF);
    chk("stuff_byte1", 32'(byte_log[b0 + 1]), 32'hFF);
    chk("stuff_rx_err", 32'(rx_err), 32'h0);
    chk("stuff_pkt_ok", 32'(pkt_ok), 32'h1);

    // seven consecutive raw ones -> stuff error
    b0 = n_byte;
    start_pkt();
    tx_byte(8'hC3, 1'b1);
    repeat (5) tx_bit_s(1'b1, 1'b0);
    chk("stufferr_rx_err", 32'(rx_err), 32'h02);
    chk("stufferr_active", 32'(rx_active), 32'h1);
    repeat (3) tx_bit(1'b1);
    eop();
    chk("stufferr_eop", 32'(eop_done), 32'h1);
    chk("stufferr_pkt_ok", 32'(pkt_ok), 32'h0);
    chk("stufferr_no_bytes", 32'(n_byte - b0), 32'h0);

    // bad PID check nibble, then EOP after 3 data bits
    p0 = n_pid;
    start_pkt();
    tx_byte(8'hD3, 1'b1);
    chk("badpid_pid_valid", 32'(pid_valid), 32'h1);
    chk("badpid_pid", 32'(pid), 32'h3);
    chk("badpid_rx_err", 32'(rx_err), 32'h01);
    tx_bit_s(1'b1, 1'b1); tx_bit_s(1'b0, 1'b1); tx_bit_s(1'b1, 1'b1);
    eop();
    chk("badpid_dribble_err", 32'(rx_err), 32'h05);
    chk("badpid_pkt_ok", 32'(pkt_ok), 32'h0);
    chk("badpid_pid_pulses", 32'(n_pid - p0), 32'h1);

    // good PID, dribble only; errors of the previous packet cleared at SYNC
    start_pkt();
    chk("err_cleared_on_sync", 32'(rx_err), 32'h0);
    tx_byte(8'hD2, 1'b1);
    tx_bit_s(1'b1, 1'b1); tx_bit_s(1'b0, 1'b1); tx_bit_s(1'b1, 1'b1);
    eop();
    chk("dribble_rx_err", 32'(rx_err), 32'h04);
    chk("dribble_pkt_ok", 32'(pkt_ok), 32'h0);

    // overflow: 5 bytes with MAX_BYTES=4
    b0 = n_byte; e0 = n_eop;
    start_pkt();
    tx_byte(8'hC3, 1'b1);
    tx_byte(8'h11, 1'b1);
    tx_byte(8'h22, 1'b1);
    tx_byte(8'h33, 1'b1);
    tx_byte(8'h44, 1'b1);
    tx_byte(8'h55, 1'b1);
    chk("ovf_no_5th_valid", 32'(byte_valid), 32'h0);
    chk("ovf_rx_err", 32'(rx_err), 32'h08);
    eop();
    chk("ovf_byte_pulses", 32'(n_byte - b0), 32'h4);
    chk("ovf_byte3", 32'(byte_log[b0 + 3]), 32'h44);
    chk("ovf_byte_count", 32'(byte_count), 32'h4);
    chk("ovf_eop_pulses", 32'(n_eop - e0), 32'h1);
    chk("ovf_last_ok", 32'(last_ok), 32'h0);

    // rx_en dropped mid-DATA
    b0 = n_byte; e0 = n_eop;
    start_pkt();
    tx_byte(8'hC3, 1'b1);
    tx_byte(8'hA5, 1'b1);
    tx_bit_s(1'b1, 1'b1);
    tx_bit_s(1'b0, 1'b1);
    rx_en = 1'b0;
    tx_bit(1'b1);
    chk("rxen_drop_active", 32'(rx_active), 32'h0);
    eop();
    chk("rxen_drop_no_eop", 32'(n_eop - e0), 32'h0);
    chk("rxen_drop_bytes", 32'(n_byte - b0), 32'h1);
    chk("rxen_drop_err_kept", 32'(rx_err), 32'h0);

    // HUNT timeout: SYNC ending on the 17th hunt cycle is missed
    rx_en = 1'b0;
    step(1'b1, 1'b0);
    rx_en = 1'b1;
    step(1'b1, 1'b0);
    repeat (9) step(1'b1, 1'b0);
    sync_seq();
    chk("timeout_sync_missed", 32'(rx_active), 32'h0);
    repeat (3) step(1'b1, 1'b0);
    cur_j = 1'b1;
    chk("timeout_still_idle", 32'(rx_active), 32'h0);

    // SYNC ending on the 16th hunt cycle is still caught
    e0 = n_eop;
    rx_en = 1'b0;
    step(1'b1, 1'b0);
    rx_en = 1'b1;
    step(1'b1, 1'b0);
    repeat (8) step(1'b1, 1'b0);
    sync_seq();
    chk("timeout_last_cycle_sync", 32'(rx_active), 32'h1);
    eop();
    chk("short_pid_err", 32'(rx_err), 32'h04);
    chk("short_pid_eop", 32'(n_eop - e0), 32'h1);

    // async reset mid-packet
    e0 = n_eop;
    start_pkt();
    tx_byte(8'hC3, 1'b1);
    tx_byte(8'h5A, 1'b1);
    tx_bit_s(1'b1, 1'b1);
    tx_bit_s(1'b0, 1'b1);
    #2 reset_n = 1'b0;
    #1 chk("midpkt_reset_outputs", all_out(), 32'h0);
    @(negedge clock);
    reset_n = 1'b1;
    cur_j = 1'b1;
    ones = 0;
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    chk("midpkt_reset_no_eop", 32'(n_eop - e0), 32'h0);

    // recovery ACK after reset
    start_pkt();
    tx_byte(8'hD2, 1'b1);
    eop();
    chk("recover_pid", 32'(pid), 32'h2);
    chk("recover_eop", 32'(eop_done), 32'h1);
    chk("recover_pkt_ok", 32'(pkt_ok), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
